// File: rtl/seq_cmp_pkg.sv
// Shared types and constants for the sequential word comparator.
//   state_t : controller states (IDLE, RUN, DONE)
//   SLICE_W : bits compared per clock by the shared equality slice
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 2;

endpackage : seq_cmp_pkg

// File: rtl/seq_word_comparator_eq2_slice.sv
// Purely combinational 2-bit equality slice, time-shared by the controller.
//   x, y : the two slices to compare
//   eq   : 1 when x == y
module eq2_slice
  import seq_cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  output logic               eq
);

  assign eq = &(x ~^ y);

endmodule : eq2_slice

// File: rtl/seq_word_comparator.sv
// Sequential equality checker: compares two WIDTH-bit words one 2-bit slice
// per clock (LSB slice first) through a single shared eq2_slice.
//   clk, rst_n   : clock and asynchronous active-low reset
//   start        : request, sampled only while idle; a and b captured then
//   a, b         : operands
//   busy         : high while slices are being compared
//   done         : one-cycle pulse when the result is updated
//   equal        : 1 when the words matched
//   mismatch_idx : lowest mismatching slice (0 when equal)
module seq_word_comparator
  import seq_cmp_pkg::*;
#(
  parameter int  WIDTH      = 8,
  parameter bit  EARLY_EXIT = 1'b1,
  localparam int NS         = WIDTH / SLICE_W,
  localparam int IW         = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [IW-1:0]    mismatch_idx
);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $fatal(1, "seq_word_comparator: WIDTH must be even and >= 2");
  end

  state_t             state, state_n;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [IW-1:0]      idx, idx_n;
  logic [IW-1:0]      first_q, first_n;   // first mismatch seen during a full scan
  logic               sticky, sticky_n;
  logic               equal_n;
  logic [IW-1:0]      midx_n;
  logic               load;
  logic               last;
  logic               slice_eq;

  eq2_slice u_slice (
    .x  (a_q[SLICE_W*idx +: SLICE_W]),
    .y  (b_q[SLICE_W*idx +: SLICE_W]),
    .eq (slice_eq)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    first_n  = first_q;
    sticky_n = sticky;
    equal_n  = equal;
    midx_n   = mismatch_idx;
    load     = 1'b0;
    last     = (idx == IW'(NS - 1));
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          idx_n    = '0;
          sticky_n = 1'b0;
          state_n  = RUN;
        end
      end
      RUN: begin
        if (!slice_eq && EARLY_EXIT) begin
          equal_n = 1'b0;
          midx_n  = idx;
          state_n = DONE;
        end else begin
          if (!slice_eq && !sticky) begin
            first_n  = idx;
            sticky_n = 1'b1;
          end
          if (last) begin
            equal_n = !(sticky || !slice_eq);
            // Lowest mismatch wins; the current slice only counts if none
            // was recorded earlier. Equal results report index 0.
            if (sticky)        midx_n = first_q;
            else if (slice_eq) midx_n = '0;
            else               midx_n = idx;
            state_n = DONE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the operand registers are plain flops, so they are reset along
  // with everything else to give a fully defined post-reset state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      idx          <= '0;
      first_q      <= '0;
      sticky       <= 1'b0;
      equal        <= 1'b0;
      mismatch_idx <= '0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      first_q      <= first_n;
      sticky       <= sticky_n;
      equal        <= equal_n;
      mismatch_idx <= midx_n;
      if (load) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

endmodule : seq_word_comparator

// File: tb/tb_seq_word_comparator.sv
// Bench for seq_word_comparator: one early-exit and one full-scan instance
// share the same stimulus and are compared every cycle against a
// transaction-level model, plus hand-computed latency/result literals.
module tb_seq_word_comparator;

  localparam int W  = 8;
  localparam int NS = W / 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;

  logic       busy0, done0, equal0;
  logic       busy1, done1, equal1;
  logic [1:0] midx0, midx1;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  seq_word_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .equal(equal0), .mismatch_idx(midx0)
  );

  seq_word_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_fs (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .equal(equal1), .mismatch_idx(midx1)
  );

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Model: instance 0 exits early, instance 1 scans all slices.
  function automatic int first_mm(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = 0; i < NS; i++)
      if (x[2*i +: 2] != y[2*i +: 2]) return i;
    return NS;
  endfunction

  int m_rem  [2];
  bit m_done [2];
  bit m_eq   [2];
  int m_idx  [2];
  bit p_eq   [2];
  int p_idx  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_rem[i] = 0; m_done[i] = 0; m_eq[i] = 0; m_idx[i] = 0;
        p_eq[i] = 0; p_idx[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_done[i]) begin
          m_done[i] = 0;
        end else if (m_rem[i] > 0) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_done[i] = 1;
            m_eq[i]   = p_eq[i];
            m_idx[i]  = p_idx[i];
          end
        end else if (start) begin
          int j;
          j        = first_mm(a, b);
          p_eq[i]  = (j == NS);
          p_idx[i] = (j == NS) ? 0 : j;
          m_rem[i] = (i == 0 && j < NS) ? j + 1 : NS;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy_ee",  int'(busy0),  int'(m_rem[0] > 0));
    check("done_ee",  int'(done0),  int'(m_done[0]));
    check("equal_ee", int'(equal0), int'(m_eq[0]));
    check("midx_ee",  int'(midx0),  m_idx[0]);
    check("busy_fs",  int'(busy1),  int'(m_rem[1] > 0));
    check("done_fs",  int'(done1),  int'(m_done[1]));
    check("equal_fs", int'(equal1), int'(m_eq[1]));
    check("midx_fs",  int'(midx1),  m_idx[1]);
  end

  task automatic wait_done(output int lat0, output int lat1);
    lat0 = -1;
    lat1 = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done0 && lat0 < 0) lat0 = n;
      if (done1 && lat1 < 0) lat1 = n;
      if (lat0 >= 0 && lat1 >= 0) break;
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int lat_e, input int eq_e, input int idx_e,
                        input int lat_f, input int eq_f, input int idx_f);
    int l0, l1;
    @(posedge clk); #2;
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(l0, l1);
    check("lat_ee",    l0,            lat_e);
    check("lat_fs",    l1,            lat_f);
    check("res_eq_ee", int'(equal0),  eq_e);
    check("res_ix_ee", int'(midx0),   idx_e);
    check("res_eq_fs", int'(equal1),  eq_f);
    check("res_ix_fs", int'(midx1),   idx_f);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy_ee"},  int'(busy0),  0);
    check({tag, "_done_ee"},  int'(done0),  0);
    check({tag, "_equal_ee"}, int'(equal0), 0);
    check({tag, "_midx_ee"},  int'(midx0),  0);
    check({tag, "_busy_fs"},  int'(busy1),  0);
    check({tag, "_done_fs"},  int'(done1),  0);
    check({tag, "_equal_fs"}, int'(equal1), 0);
    check({tag, "_midx_fs"},  int'(midx1),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcyc [2][2];
    int deq  [2][2];
    int didx [2][2];
    int nd   [2];

    #1 check_zero("rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // equal words: busy 4 cycles, done on the 5th
    run_op(8'h3C, 8'h3C, 5, 1, 0, 5, 1, 0);
    // slice 2 differs: early exit after 3 slices
    run_op(8'hF0, 8'h00, 4, 0, 2, 5, 0, 2);

    // result hold: operands toggle without start
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #2;
      a = 8'(k * 37);
      b = ~a;
    end
    @(negedge clk);
    check("hold_eq_ee", int'(equal0), 0);
    check("hold_ix_ee", int'(midx0),  2);
    check("hold_ix_fs", int'(midx1),  2);

    // slice 0 differs: early exit after one busy cycle
    run_op(8'h01, 8'h00, 2, 0, 0, 5, 0, 0);
    // slice 1 differs
    run_op(8'h0C, 8'h00, 3, 0, 1, 5, 0, 1);

    // start held high; a changes after capture
    for (int i = 0; i < 2; i++) begin
      nd[i] = 0;
      for (int j = 0; j < 2; j++) begin
        dcyc[i][j] = -1; deq[i][j] = -1; didx[i][j] = -1;
      end
    end
    @(posedge clk); #2;
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #2;
      if (k == 1) a = 8'h00;
      if (k == 7) start = 1'b0;
      @(negedge clk);
      if (done0 && nd[0] < 2) begin
        dcyc[0][nd[0]] = k + 1; deq[0][nd[0]] = int'(equal0); didx[0][nd[0]] = int'(midx0);
        nd[0]++;
      end
      if (done1 && nd[1] < 2) begin
        dcyc[1][nd[1]] = k + 1; deq[1][nd[1]] = int'(equal1); didx[1][nd[1]] = int'(midx1);
        nd[1]++;
      end
    end
    check("held_d1cyc_ee", dcyc[0][0], 5);
    check("held_d1eq_ee",  deq[0][0],  1);
    check("held_d2cyc_ee", dcyc[0][1], 8);
    check("held_d2eq_ee",  deq[0][1],  0);
    check("held_d2ix_ee",  didx[0][1], 0);
    check("held_d1cyc_fs", dcyc[1][0], 5);
    check("held_d1eq_fs",  deq[1][0],  1);
    check("held_d2cyc_fs", dcyc[1][1], 11);
    check("held_d2eq_fs",  deq[1][1],  0);
    check("held_d2ix_fs",  didx[1][1], 0);
    repeat (2) @(posedge clk);

    // leave a nonzero result, then reset in the middle of a run
    run_op(8'hFF, 8'hFF, 5, 1, 0, 5, 1, 0);
    @(posedge clk); #2;
    a = 8'hA5; b = 8'hA5; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_zero("midrun");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // normal operation after reset
    run_op(8'h80, 8'h00, 5, 0, 3, 5, 0, 3);
    run_op(8'h12, 8'h32, 4, 0, 2, 5, 0, 2);
    run_op(8'hA5, 8'hA5, 5, 1, 0, 5, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_seq_word_comparator
